// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM state encoding and width helpers for the set-associative cache
package cache_pkg;
  typedef logic [1:0] state_e;
  localparam state_e IDLE      = 2'd0;
  localparam state_e WRITEBACK = 2'd1;
  localparam state_e FILL      = 2'd2;
  // Index width that never collapses to zero, so single-entry fields stay declarable.
  function automatic int lg2(input int v);
    return v < 2 ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/assoc_wb_cache_if.sv
// assoc_wb_cache_if: CPU-side (mem_*) and line-wide physical memory (pmem_*) buses of the cache.
// slave = cache view, master = CPU plus physical memory view.
interface assoc_wb_cache_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LINE_W = 128
);
  logic                mem_read;
  logic                mem_write;
  logic [DATA_W/8-1:0] mem_byte_enable;
  logic [ADDR_W-1:0]   mem_address;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_resp;
  logic [DATA_W-1:0]   mem_rdata;
  logic                pmem_read;
  logic                pmem_write;
  logic [ADDR_W-1:0]   pmem_address;
  logic [LINE_W-1:0]   pmem_wdata;
  logic                pmem_resp;
  logic [LINE_W-1:0]   pmem_rdata;
  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, pmem_resp, pmem_rdata,
    output mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, pmem_resp, pmem_rdata,
    input  mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/plru_tree.sv
// plru_tree: combinational binary-tree pseudo-LRU for one set.
// Ports: bits_i current tree, way_i accessed way, bits_o tree after access, victim_o way the tree points at.
// Tree node n (heap order, root=1) lives in bit n of t; a 0 bit steers the victim search left.
module plru_tree
  import cache_pkg::*;
#(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]       bits_i,
  input  logic [lg2(WAYS)-1:0]  way_i,
  output logic [WAYS-2:0]       bits_o,
  output logic [lg2(WAYS)-1:0]  victim_o
);
  localparam int L = lg2(WAYS);
  logic [WAYS-1:0] t;
  logic [L-1:0] vn, an, w;
  // The leading 1 of the heap index shifts out after L steps, leaving the leaf number.
  always_comb begin
    t = {bits_i, 1'b0};
    vn = L'(1);
    an = L'(1);
    w = way_i;
    for (int l = 0; l < L; l++) vn = (vn << 1) | L'(t[vn]);
    for (int l = 0; l < L; l++) begin
      t[an] = ~w[L-1];
      an = (an << 1) | L'(w[L-1]);
      w = w << 1;
    end
  end
  assign bits_o = t[WAYS-1:1];
  assign victim_o = vn;
endmodule

// File: rtl/assoc_wb_cache.sv
// assoc_wb_cache: N-way set-associative write-back write-allocate cache with tree pseudo-LRU.
// Ports: clk, rst_n (async active-low), bus (slave): mem_* CPU word port, pmem_* line-wide memory port.
module assoc_wb_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LINE_W = 128,
  parameter int SETS   = 8,
  parameter int WAYS   = 4
) (
  input logic clk,
  input logic rst_n,
  assoc_wb_cache_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = lg2(LINE_W / 8);
  localparam int IDX_W = lg2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WORDS = LINE_W / DATA_W;
  localparam int WS_W  = lg2(WORDS);
  localparam int BO_W  = lg2(BE_W);
  localparam int WAY_W = lg2(WAYS);
  typedef logic [WORDS-1:0][DATA_W-1:0] line_t;
  state_e state_q, state_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [WAYS-1:0] valid_q [SETS], valid_d [SETS];
  logic [WAYS-1:0] dirty_q [SETS], dirty_d [SETS];
  logic [WAYS-2:0] plru_q [SETS], plru_d [SETS];
  logic [TAG_W-1:0] tag_q [WAYS][SETS], tag_d [WAYS][SETS];
  line_t data_q [WAYS][SETS], data_d [WAYS][SETS];
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] idx;
  logic [WS_W-1:0] wsel;
  logic req, hit, any_inv;
  logic [WAYS-1:0] hit_vec;
  logic [WAY_W-1:0] hit_way, inv_way, plru_vic, victim;
  logic [WAYS-2:0] plru_upd;
  assign req_tag = bus.mem_address[ADDR_W-1 -: TAG_W];
  assign idx = bus.mem_address[OFF_W +: IDX_W];
  assign wsel = bus.mem_address[BO_W +: WS_W];
  assign req = bus.mem_read | bus.mem_write;
  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    inv_way = '0;
    any_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = valid_q[idx][w] && tag_q[w][idx] == req_tag;
      hit_way = hit_vec[w] ? WAY_W'(w) : hit_way;
      inv_way = !valid_q[idx][w] ? WAY_W'(w) : inv_way;
      any_inv = any_inv | !valid_q[idx][w];
    end
  end
  assign hit = |hit_vec;
  assign victim = any_inv ? inv_way : plru_vic;
  plru_tree #(.WAYS(WAYS)) u_plru (
    .bits_i  (plru_q[idx]),
    .way_i   (hit_way),
    .bits_o  (plru_upd),
    .victim_o(plru_vic)
  );
  assign bus.mem_resp = state_q == IDLE && req && hit;
  assign bus.mem_rdata = data_q[hit_way][idx][wsel];
  assign bus.pmem_read = state_q == FILL;
  assign bus.pmem_write = state_q == WRITEBACK;
  // Victim tag is untouched until the fill lands, so the address holds for the whole miss.
  assign bus.pmem_address = state_q == WRITEBACK ? {tag_q[victim_q][idx], idx, OFF_W'(0)} :
                            state_q == FILL      ? {req_tag, idx, OFF_W'(0)} : '0;
  assign bus.pmem_wdata = data_q[victim_q][idx];
  always_comb begin
    state_d = state_q;
    victim_d = victim_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    plru_d = plru_q;
    tag_d = tag_q;
    data_d = data_q;
    if (state_q == IDLE && req && hit) begin
      plru_d[idx] = plru_upd;
      if (bus.mem_write) begin
        dirty_d[idx][hit_way] = 1'b1;
        for (int b = 0; b < BE_W; b++)
          if (bus.mem_byte_enable[b]) data_d[hit_way][idx][wsel][b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
      end
    end else if (state_q == IDLE && req) begin
      victim_d = victim;
      state_d = valid_q[idx][victim] && dirty_q[idx][victim] ? WRITEBACK : FILL;
    end else if (state_q == WRITEBACK && bus.pmem_resp) begin
      state_d = FILL;
    end else if (state_q == FILL && bus.pmem_resp) begin
      data_d[victim_q][idx] = bus.pmem_rdata;
      tag_d[victim_q][idx] = req_tag;
      valid_d[idx][victim_q] = 1'b1;
      dirty_d[idx][victim_q] = 1'b0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      victim_q <= '0;
      valid_q <= '{default: '0};
      dirty_q <= '{default: '0};
      plru_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      victim_q <= victim_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      plru_q <= plru_d;
    end
  end
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    data_q <= data_d;
  end
  a_stable_miss: assert property (@(posedge clk) disable iff (!rst_n)
    state_q != IDLE |-> $stable(bus.mem_address) && $stable(bus.mem_wdata) && $stable(bus.mem_byte_enable));
  a_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    req |-> bus.mem_address[BO_W-1:0] == '0);
endmodule

// File: tb/tb_assoc_wb_cache.sv
// tb_assoc_wb_cache: scoreboard bench for assoc_wb_cache with a fixed-latency line memory model
module tb_assoc_wb_cache;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  assoc_wb_cache_if #(.ADDR_W(16), .DATA_W(16), .LINE_W(128)) bus ();
  assoc_wb_cache #(.ADDR_W(16), .DATA_W(16), .LINE_W(128), .SETS(8), .WAYS(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  typedef struct {logic rd; logic [15:0] data;} mexp_t;
  typedef struct {logic wr; logic [15:0] addr; logic [127:0] line;} pexp_t;
  mexp_t mq[$];
  pexp_t pq[$];
  int checks = 0;
  int failures = 0;
  logic [15:0] ref_mem [32768];
  logic [127:0] pmem [4096];

  function automatic logic [127:0] ref_line(logic [15:0] a);
    logic [127:0] r;
    for (int j = 0; j < 8; j++) r[j*16 +: 16] = ref_mem[{a[15:4], 3'(j)}];
    return r;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic flag(string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  task automatic xact(logic wr, logic [15:0] a, logic [15:0] d, logic [1:0] be, logic [15:0] exp,
                      int lat, logic wb = 1'b0, logic [15:0] wba = 16'h0);
    mexp_t m;
    pexp_t p;
    int cyc;
    if (lat > 0) begin
      if (wb) begin
        p.wr = 1'b1; p.addr = wba; p.line = ref_line(wba);
        pq.push_back(p);
      end
      p.wr = 1'b0; p.addr = {a[15:4], 4'h0}; p.line = '0;
      pq.push_back(p);
    end
    if (wr) for (int b = 0; b < 2; b++) if (be[b]) ref_mem[a[15:1]][b*8 +: 8] = d[b*8 +: 8];
    m.rd = !wr; m.data = exp;
    mq.push_back(m);
    bus.mem_address = a; bus.mem_wdata = d; bus.mem_byte_enable = be;
    bus.mem_read = !wr; bus.mem_write = wr;
    cyc = 0;
    @(negedge clk);
    while (!bus.mem_resp && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("latency@%h", a), 128'(cyc), 128'(lat));
    @(posedge clk);
    #1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
  endtask

  task automatic rd(logic [15:0] a, logic [15:0] exp, int lat, logic wb = 1'b0, logic [15:0] wba = 16'h0);
    xact(1'b0, a, 16'h0, 2'b00, exp, lat, wb, wba);
  endtask

  task automatic wr(logic [15:0] a, logic [15:0] d, logic [1:0] be);
    xact(1'b1, a, d, be, 16'h0, 0);
  endtask

  initial begin : monitor
    mexp_t e;
    forever begin
      @(negedge clk);
      if (bus.mem_resp) begin
        if (mq.size() == 0) flag("unexpected mem_resp");
        else begin
          e = mq.pop_front();
          if (e.rd) chk("rdata", 128'(bus.mem_rdata), 128'(e.data));
        end
      end
    end
  end

  initial begin : phys_mem
    pexp_t e;
    logic [15:0] a;
    bus.pmem_resp = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.pmem_read || bus.pmem_write) begin
        chk("pmem rd&wr", 128'(bus.pmem_read & bus.pmem_write), 128'(0));
        a = bus.pmem_address;
        if (pq.size() == 0) flag($sformatf("unexpected pmem access @%h", a));
        else begin
          e = pq.pop_front();
          chk("pmem_write", 128'(bus.pmem_write), 128'(e.wr));
          chk("pmem_address", 128'(a), 128'(e.addr));
          if (e.wr) chk("wb_line", bus.pmem_wdata, e.line);
        end
        if (bus.pmem_write) pmem[a[15:4]] = bus.pmem_wdata;
        repeat (LAT) @(posedge clk);
        #1;
        bus.pmem_rdata = pmem[a[15:4]];
        bus.pmem_resp = 1'b1;
        @(posedge clk);
        #1;
        bus.pmem_resp = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    pexp_t p;
    for (int i = 0; i < 32768; i++) ref_mem[15'(i)] = 16'(i << 1) ^ 16'hC3A5;
    for (int l = 0; l < 4096; l++) pmem[12'(l)] = ref_line({12'(l), 4'h0});
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.mem_byte_enable = '0; bus.mem_address = '0; bus.mem_wdata = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst mem_resp", 128'(bus.mem_resp), 128'(0));
    chk("rst pmem_read", 128'(bus.pmem_read), 128'(0));
    chk("rst pmem_write", 128'(bus.pmem_write), 128'(0));
    chk("rst pmem_address", 128'(bus.pmem_address), 128'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(16'h0000, 16'hC3A5, 4);
    rd(16'h0002, 16'hC3A7, 0);
    wr(16'h0002, 16'h600D, 2'b10);
    rd(16'h0002, 16'h60A7, 0);
    rd(16'h0080, 16'hC325, 4);
    rd(16'h0100, 16'hC2A5, 4);
    rd(16'h0180, 16'hC225, 4);
    rd(16'h0000, 16'hC3A5, 0);
    rd(16'h0080, 16'hC325, 0);
    rd(16'h0100, 16'hC2A5, 0);
    rd(16'h0180, 16'hC225, 0);
    rd(16'h0200, 16'hC1A5, 7, 1'b1, 16'h0000);
    rd(16'h0000, 16'hC3A5, 4);
    rd(16'h0002, 16'h60A7, 0);
    wr(16'h0080, 16'h600D, 2'b11);
    rd(16'h0200, 16'hC1A5, 0);
    rd(16'h0180, 16'hC225, 0);
    rd(16'h0280, 16'hC125, 7, 1'b1, 16'h0080);
    chk("pmem holds 600D", 128'(pmem[12'h008][15:0]), 128'(16'h600D));
    rd(16'h0080, 16'h600D, 4);
    rd(16'h0010, 16'hC3B5, 4);
    wr(16'h0014, 16'hBEEF, 2'b01);
    rd(16'h0014, 16'hC3EF, 0);
    wr(16'h0016, 16'h1234, 2'b00);
    rd(16'h0016, 16'hC3B3, 0);
    p.wr = 1'b0; p.addr = 16'h0030; p.line = '0;
    pq.push_back(p);
    bus.mem_address = 16'h0030; bus.mem_read = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("fill active", 128'(bus.pmem_read), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("reset drops pmem_read", 128'(bus.pmem_read), 128'(0));
    chk("reset pmem_write", 128'(bus.pmem_write), 128'(0));
    bus.mem_read = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rd(16'h0002, 16'h60A7, 4);
    repeat (4) @(posedge clk);
    chk("mem queue drained", 128'(mq.size()), 128'(0));
    chk("pmem queue drained", 128'(pq.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
